// File: rtl/qsys_pio_pkg.sv
// Shared definitions for the pulse-capable PIO output block.
// Holds the Avalon-MM word-address map and the default widths used by
// qsys_pio_out_pulse and its per-bit pulse channel.
package qsys_pio_pkg;

  // Default widths
  localparam int unsigned DefDataWidth = 8;
  localparam int unsigned DefCntWidth  = 16;
  localparam int unsigned BusWidth     = 32;

  // Register word addresses
  localparam logic [2:0] AddrData     = 3'd0;  // RW
  localparam logic [2:0] AddrPulseLen = 3'd1;  // RW
  localparam logic [2:0] AddrTrigger  = 3'd2;  // W trigger / R busy
  localparam logic [2:0] AddrIrqMask  = 3'd3;  // RW
  localparam logic [2:0] AddrOutSet   = 3'd4;  // W, reads 0
  localparam logic [2:0] AddrOutClear = 3'd5;  // W, reads 0
  localparam logic [2:0] AddrDone     = 3'd6;  // R, write-1-to-clear
  localparam logic [2:0] AddrReserved = 3'd7;  // reads 0, writes ignored

endpackage

// File: rtl/pio_pulse_chan.sv
// One output bit's pulse timer.
// A load with a non-zero length starts (or restarts) a pulse of exactly len_i
// cycles; busy_o is high for that time and done_o is set on the edge where
// busy_o falls. done_o is cleared by clr_i unless a set happens the same cycle.
//
// Ports:
//   clk_i    clock, rising edge
//   srst_ni  synchronous active-low reset
//   trig_i   trigger strobe for this bit
//   len_i    pulse length captured on trigger
//   clr_i    done clear strobe (write-1-to-clear)
//   busy_o   pulse in progress
//   done_o   sticky pulse-finished flag
module pio_pulse_chan
  import qsys_pio_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = DefCntWidth
) (
  input  logic                 clk_i,
  input  logic                 srst_ni,
  input  logic                 trig_i,
  input  logic [CNT_WIDTH-1:0] len_i,
  input  logic                 clr_i,
  output logic                 busy_o,
  output logic                 done_o
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 load;
  logic                 last;

  // A zero-length trigger is a no-op.
  assign load = trig_i && (len_i != '0);
  assign last = busy_q && (cnt_q == CNT_WIDTH'(1));

  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = done_q;

    if (last) begin
      cnt_d  = '0;
      busy_d = 1'b0;
    end else if (busy_q) begin
      cnt_d = cnt_q - CNT_WIDTH'(1);
    end

    // Retrigger reloads the counter and overrides the final count.
    if (load) begin
      cnt_d  = len_i;
      busy_d = 1'b1;
    end

    if (clr_i) begin
      done_d = 1'b0;
    end
    // Set after clear so a coincident set wins.
    if (last && !load) begin
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!srst_ni) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: rtl/qsys_pio_out_pulse.sv
// Avalon-MM PIO output port with per-bit timed pulses.
// Each pin is the data register XOR the bit's pulse-busy flag, so a pulse
// inverts whatever level the data register holds while it runs.
//
// Ports:
//   clk         clock, rising edge
//   reset_n     synchronous active-low reset
//   address     word address (see qsys_pio_pkg)
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data, upper unused bits ignored
//   readdata    registered read data, zero-extended, 1-cycle latency
//   out_port    driven pins
//   irq         level interrupt, OR of done & irq_mask
module qsys_pio_out_pulse
  import qsys_pio_pkg::*;
#(
  parameter int unsigned            DATA_WIDTH  = DefDataWidth,
  parameter logic [DATA_WIDTH-1:0]  RESET_VALUE = '0,
  parameter int unsigned            CNT_WIDTH   = DefCntWidth
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [BusWidth-1:0]   writedata,
  output logic [BusWidth-1:0]   readdata,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  irq
);

  logic                  wr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  trig_wr;
  logic                  done_wr;

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CNT_WIDTH-1:0]  len_q, len_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic [BusWidth-1:0]   readdata_q, readdata_d;

  logic [DATA_WIDTH-1:0] busy;
  logic [DATA_WIDTH-1:0] done;

  logic                  unused_wd;

  assign wr        = chipselect && !write_n;
  assign wdata     = writedata[DATA_WIDTH-1:0];
  assign trig_wr   = wr && (address == AddrTrigger);
  assign done_wr   = wr && (address == AddrDone);
  assign unused_wd = ^writedata;

  // Register write decode
  always_comb begin
    data_d = data_q;
    len_d  = len_q;
    mask_d = mask_q;
    if (wr) begin
      case (address)
        AddrData:     data_d = wdata;
        AddrPulseLen: len_d  = writedata[CNT_WIDTH-1:0];
        AddrIrqMask:  mask_d = wdata;
        AddrOutSet:   data_d = data_q | wdata;
        AddrOutClear: data_d = data_q & ~wdata;
        default:      ;
      endcase
    end
  end

  // Read mux, loaded every cycle regardless of chipselect
  always_comb begin
    readdata_d = '0;
    case (address)
      AddrData:     readdata_d[DATA_WIDTH-1:0] = data_q;
      AddrPulseLen: readdata_d[CNT_WIDTH-1:0]  = len_q;
      AddrTrigger:  readdata_d[DATA_WIDTH-1:0] = busy;
      AddrIrqMask:  readdata_d[DATA_WIDTH-1:0] = mask_q;
      AddrDone:     readdata_d[DATA_WIDTH-1:0] = done;
      default:      readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_q     <= RESET_VALUE;
      len_q      <= '0;
      mask_q     <= '0;
      readdata_q <= '0;
    end else begin
      data_q     <= data_d;
      len_q      <= len_d;
      mask_q     <= mask_d;
      readdata_q <= readdata_d;
    end
  end

  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_chan
    pio_pulse_chan #(
      .CNT_WIDTH(CNT_WIDTH)
    ) u_chan (
      .clk_i  (clk),
      .srst_ni(reset_n),
      .trig_i (trig_wr && wdata[i]),
      .len_i  (len_q),
      .clr_i  (done_wr && wdata[i]),
      .busy_o (busy[i]),
      .done_o (done[i])
    );
  end

  assign readdata = readdata_q;
  assign out_port = data_q ^ busy;
  assign irq      = |(done & mask_q);

endmodule

// File: tb/tb_qsys_pio_out_pulse.sv
// Directed bench for qsys_pio_out_pulse (default parameters).
// Inputs change and outputs are sampled on the falling edge.
module tb_qsys_pio_out_pulse;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;

  qsys_pio_out_pulse dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .out_port  (out_port),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the write edge.
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    address = a;
    @(negedge clk);
    d = readdata;
  endtask

  // Counts consecutive samples where out_port[bit] equals lvl (bounded).
  task automatic count_level(input int b, input logic lvl, output int n);
    n = 0;
    while (out_port[b] == lvl && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    logic [31:0] rd;
    int          n;

    reset_n    = 1'b0;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_out_port", 32'(out_port), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_readdata", readdata, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // Data write and readback
    bus_write(3'd0, 32'h0000_00A5);
    check("data_out_port", 32'(out_port), 32'hA5);
    bus_read(3'd0, rd);
    check("data_read", rd, 32'h0000_00A5);

    // Set / clear
    bus_write(3'd4, 32'h0A);
    check("outset", 32'(out_port), 32'hAF);
    bus_write(3'd5, 32'h81);
    check("outclear", 32'(out_port), 32'h2E);
    bus_read(3'd4, rd);
    check("outset_reads0", rd, 32'h0);
    bus_read(3'd7, rd);
    check("reserved_reads0", rd, 32'h0);

    // Basic pulse, done, irq and W1C
    bus_write(3'd0, 32'h0);
    bus_write(3'd1, 32'd5);
    bus_read(3'd1, rd);
    check("pulse_len_read", rd, 32'd5);
    bus_write(3'd3, 32'h01);
    bus_read(3'd3, rd);
    check("irq_mask_read", rd, 32'h01);
    bus_write(3'd2, 32'h01);
    check("irq_during_pulse", 32'(irq), 32'h0);
    count_level(0, 1'b1, n);
    check("pulse5_len", 32'(n), 32'd5);
    check("irq_after_pulse", 32'(irq), 32'h1);
    bus_read(3'd6, rd);
    check("done_after_pulse", rd, 32'h01);
    bus_write(3'd6, 32'h01);
    check("irq_after_w1c", 32'(irq), 32'h0);

    // Retrigger on the final count extends the pulse without a done
    bus_write(3'd3, 32'h02);
    bus_write(3'd1, 32'd4);
    bus_write(3'd2, 32'h02);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      if (out_port[1]) n++;
      @(negedge clk);
    end
    if (out_port[1]) n++;
    check("retrig_first_part", 32'(n), 32'd4);
    bus_write(3'd2, 32'h02);
    check("retrig_no_done", 32'(irq), 32'h0);
    count_level(1, 1'b1, n);
    check("retrig_extend_len", 32'(n), 32'd4);
    bus_read(3'd6, rd);
    check("retrig_done_once", rd, 32'h02);
    bus_write(3'd6, 32'h02);
    bus_read(3'd6, rd);
    check("retrig_done_cleared", rd, 32'h0);

    // Done set beats a coincident W1C (1-cycle pulse)
    bus_write(3'd1, 32'd1);
    bus_write(3'd2, 32'h04);
    bus_write(3'd6, 32'h04);
    bus_read(3'd6, rd);
    check("set_beats_w1c", rd, 32'h04);
    bus_write(3'd6, 32'hFF);

    // Zero-length trigger is ignored
    bus_write(3'd0, 32'h3C);
    bus_write(3'd3, 32'hFF);
    bus_write(3'd1, 32'd0);
    bus_write(3'd2, 32'hFF);
    check("len0_out_port", 32'(out_port), 32'h3C);
    bus_read(3'd2, rd);
    check("len0_busy", rd, 32'h0);
    bus_read(3'd6, rd);
    check("len0_done", rd, 32'h0);
    check("len0_irq", 32'(irq), 32'h0);

    // Pulse inverts a high level; a later length change does not affect it
    bus_write(3'd1, 32'd3);
    bus_write(3'd2, 32'h10);
    check("invert_low", 32'(out_port), 32'h2C);
    n = 1;
    bus_write(3'd1, 32'd7);
    begin
      int m;
      count_level(4, 1'b0, m);
      n = n + m;
    end
    check("len_change_later", 32'(n), 32'd3);
    check("invert_restored", 32'(out_port), 32'h3C);
    bus_write(3'd6, 32'hFF);

    // Reset mid-pulse
    bus_write(3'd1, 32'd10);
    bus_write(3'd2, 32'h80);
    check("long_pulse_on", 32'(out_port), 32'hBC);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_out_port", 32'(out_port), 32'h0);
    check("midrst_irq", 32'(irq), 32'h0);
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) @(negedge clk);
    check("midrst_out_after", 32'(out_port), 32'h0);
    bus_read(3'd6, rd);
    check("midrst_done", rd, 32'h0);
    bus_read(3'd1, rd);
    check("midrst_len", rd, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/qsys_pio_out_pulse.md
QSYS_PIO_OUT_PULSE -- requirements
Module: qsys_pio_out_pulse

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the width of out_port and all per-bit registers.
REQ-002 Parameter RESET_VALUE, default 0, SHALL set the data register value after reset.
REQ-003 Parameter CNT_WIDTH, default 16, SHALL set the pulse-length register and counter width.
REQ-004 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-005 reset_n  input  1  reset, synchronous, active-low.
REQ-006 address  input  3  Avalon-MM word address.
REQ-007 chipselect  input  1  slave select.
REQ-008 write_n  input  1  write strobe, active-low; a write is chipselect && ~write_n.
REQ-009 writedata  input  32  write data; bits above the register width are ignored.
REQ-010 readdata  output  32  registered read data, zero-extended.
REQ-011 out_port  output  DATA_WIDTH  driven pins.
REQ-012 irq  output  1  level interrupt.

Function
REQ-013 Register map: 0 data (RW); 1 pulse_len (RW, CNT_WIDTH); 2 trigger (W) / busy (R); 3 irq_mask (RW); 4 outset (W, reads 0); 5 outclear (W, reads 0); 6 done (R, write-1-to-clear); 7 reserved (reads 0, writes ignored).
REQ-014 readdata SHALL load the addressed register on every clock, regardless of chipselect; read latency is 1 cycle.
REQ-015 A write to 4 SHALL OR writedata into data; a write to 5 SHALL clear the data bits where writedata is 1.
REQ-016 out_port SHALL equal data XOR busy, both taken from flops; a write at edge k SHALL appear on out_port directly after edge k.
REQ-017 A trigger write with pulse_len=L>0 SHALL load the counter of each bit i with writedata[i]=1 to L and set busy[i].
REQ-018 busy[i] SHALL stay 1 for exactly L cycles, then clear; done[i] SHALL set on the edge where busy[i] clears.
REQ-019 A trigger with L=0 SHALL be ignored: busy and done do not change.
REQ-020 A retrigger of a busy bit SHALL reload the counter to the current L (extend); if it coincides with the final count, the reload wins and done is not set.
REQ-021 A change to pulse_len SHALL affect only later triggers.
REQ-022 If a done W1C and a done-set hit the same bit in the same cycle, the set SHALL win.
REQ-023 irq SHALL equal OR(done AND irq_mask), with no extra register stage.
REQ-024 A data, outset or outclear write to a busy bit SHALL change the underlying level; the pulse inverts the new level until it ends.

Reset
REQ-025 While reset_n=0 at a clock edge, the following SHALL load: data=RESET_VALUE, pulse_len=0, irq_mask=0, busy=0, done=0, all counters=0, readdata=0.
REQ-026 After reset, irq=0 and out_port=RESET_VALUE.
REQ-027 Reset in mid-pulse SHALL end the pulse immediately and SHALL NOT set done.

Structure
REQ-028 The register address constants (0-7) and the default widths SHALL live in the shared package qsys_pio_pkg.
REQ-029 Per-bit counter/busy/done logic SHALL be one sub-module, pio_pulse_chan, instantiated DATA_WIDTH times by a generate loop.
REQ-030 The top level SHALL hold the bus decode, data, pulse_len and irq_mask registers, and the read mux.

Verification
REQ-031 Reset, then write data=0xA5 -> out_port=0xA5 one edge after the write; reading address 0 gives 0x000000A5 one cycle later.
REQ-032 From data=0xA5, write outset 0x0A and then outclear 0x81 -> out_port goes 0xAF, then 0x2E.
REQ-033 pulse_len=5, data=0, trigger 0x01 -> out_port[0]=1 for exactly 5 cycles; then done=0x01; with irq_mask=0x01, irq=1; a W1C of 0x01 to done drops irq the next cycle.
REQ-034 pulse_len=4, trigger 0x02; at the cycle with 1 count left, retrigger 0x02 -> busy stays set for 4 more cycles, and done sets only once.
REQ-035 pulse_len=0, trigger 0xFF -> busy=0, done=0, out_port unchanged.
REQ-036 pulse_len=10, trigger 0x80, assert reset_n=0 at cycle 3 -> out_port=RESET_VALUE, done=0, irq=0.
